// File: rtl/i2s_tdm_transmitter.sv
// Multi-channel I2S / left-justified serial audio transmitter with a divided bit
// clock, per-slot zero padding and a one-frame holding buffer with underrun pulse.
module i2s_tdm_transmitter #(
  parameter int WORD_SIZE = 24,
  parameter int SLOT_SIZE = 32,
  parameter int CHANNELS  = 2,
  parameter int CLK_DIV   = 4
) (
  input  logic                          clk,
  input  logic                          nReset,
  input  logic [CHANNELS*WORD_SIZE-1:0] sample_data,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic                          mode,
  output logic                          sclk,
  output logic                          lrclk,
  output logic                          sd,
  output logic                          frame_start,
  output logic                          underrun
);

  localparam int FRAME = CHANNELS * SLOT_SIZE;
  localparam int BW    = $clog2(FRAME);
  localparam int DW    = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_RISE = DW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(FRAME - 1);
  localparam logic [BW-1:0] B_HALF   = BW'(FRAME / 2);

  // Channel 0 goes first on the wire, so it lands in the top slot; word MSB-aligned.
  function automatic logic [FRAME-1:0] pad_frame(input logic [CHANNELS*WORD_SIZE-1:0] d);
    logic [FRAME-1:0] f;
    f = '0;
    for (int k = 0; k < CHANNELS; k++)
      f[FRAME-1-k*SLOT_SIZE -: WORD_SIZE] = d[k*WORD_SIZE +: WORD_SIZE];
    return f;
  endfunction

  logic [DW-1:0]                 div_cnt;
  logic [BW-1:0]                 bit_cnt;
  logic [BW-1:0]                 bit_nxt;
  logic [CHANNELS*WORD_SIZE-1:0] hold_data;
  logic [FRAME-1:0]              shreg;
  logic [FRAME-1:0]              load_frame;
  logic                          dly;
  logic                          mode_q;
  logic                          mode_nxt;
  logic                          fall_tick;
  logic                          load;
  logic                          accept;
  logic                          lj_bit;

  assign fall_tick  = (div_cnt == DIV_LAST);
  assign load       = fall_tick && (bit_cnt == B_LAST);
  assign bit_nxt    = (bit_cnt == B_LAST) ? '0 : bit_cnt + BW'(1);
  assign accept     = sample_valid && sample_ready;
  assign load_frame = sample_ready ? '0 : pad_frame(hold_data);
  assign lj_bit     = load ? load_frame[FRAME-1] : shreg[FRAME-1];
  assign mode_nxt   = load ? mode : mode_q;

  always_ff @(posedge clk) begin
    if (accept) hold_data <= sample_data;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      div_cnt      <= '0;
      bit_cnt      <= B_LAST;
      shreg        <= '0;
      dly          <= 1'b0;
      mode_q       <= 1'b0;
      sclk         <= 1'b0;
      lrclk        <= 1'b0;
      sd           <= 1'b0;
      sample_ready <= 1'b1;
      frame_start  <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      frame_start <= load;
      underrun    <= load && sample_ready;
      div_cnt     <= fall_tick ? '0 : div_cnt + DW'(1);
      if (div_cnt == DIV_RISE) sclk <= 1'b1;
      // Fall tick: every serial output moves together with the sclk falling edge.
      if (fall_tick) begin
        sclk    <= 1'b0;
        bit_cnt <= bit_nxt;
        lrclk   <= (bit_nxt >= B_HALF);
        shreg   <= load ? {load_frame[FRAME-2:0], 1'b0} : {shreg[FRAME-2:0], 1'b0};
        dly     <= lj_bit;
        sd      <= mode_nxt ? lj_bit : dly;
        mode_q  <= mode_nxt;
      end
      // A same-cycle accept refills the buffer after an underrun load; no bypass.
      if (accept)    sample_ready <= 1'b0;
      else if (load) sample_ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_tdm_transmitter.sv
// Directed bench for i2s_tdm_transmitter: default 2x24/32 instance plus a 4x16/16 instance.
module tb_i2s_tdm_transmitter;

  logic        clk = 1'b0;
  logic        n_reset, valid, ready, mode, sclk, lrclk, sd, fs, ur;
  logic [47:0] data;
  logic        n_reset4, valid4, ready4, mode4, sclk4, lrclk4, sd4, fs4, ur4;
  logic [63:0] data4;
  int          tests = 0;
  int          fails = 0;

  localparam logic [63:0] LR_EXP = 64'hFFFFFFFF_00000000;

  always #5 clk = ~clk;

  i2s_tdm_transmitter dut (
    .clk(clk), .nReset(n_reset), .sample_data(data), .sample_valid(valid),
    .sample_ready(ready), .mode(mode), .sclk(sclk), .lrclk(lrclk), .sd(sd),
    .frame_start(fs), .underrun(ur)
  );

  i2s_tdm_transmitter #(.WORD_SIZE(16), .SLOT_SIZE(16), .CHANNELS(4), .CLK_DIV(4)) dut4 (
    .clk(clk), .nReset(n_reset4), .sample_data(data4), .sample_valid(valid4),
    .sample_ready(ready4), .mode(mode4), .sclk(sclk4), .lrclk(lrclk4), .sd(sd4),
    .frame_start(fs4), .underrun(ur4)
  );

  // Expected wire bits indexed by bit number b (bit 0 sent first).
  function automatic logic [63:0] lj_expect(input logic [47:0] d);
    logic [63:0] e;
    for (int b = 0; b < 64; b++) begin
      if ((b % 32) < 24) e[b] = d[(b / 32) * 24 + 23 - (b % 32)];
      else               e[b] = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [63:0] i2s_expect(input logic [47:0] d, input logic prev);
    logic [63:0] lj;
    lj = lj_expect(d);
    return {lj[62:0], prev};
  endfunction

  function automatic logic [63:0] ch4_expect(input logic [63:0] d);
    logic [63:0] e;
    for (int b = 0; b < 64; b++) e[b] = d[(b / 16) * 16 + 15 - (b % 16)];
    return e;
  endfunction

  function automatic logic [47:0] mk(input int k);
    return {24'(k + 256), 24'(k)};
  endfunction

  task automatic apply_reset(input bit four);
    if (four) n_reset4 = 1'b0; else n_reset = 1'b0;
    repeat (3) @(negedge clk);
    if (four) n_reset4 = 1'b1; else n_reset = 1'b1;
  endtask

  task automatic wait_fs(input bit four, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (four ? fs4 : fs) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Entered on the negedge where b=0 is on the wire; leaves on the last negedge of the frame.
  task automatic capture(input bit four, output logic [63:0] sdb, output logic [63:0] lrb,
                         output logic fs0, output logic ur0, output int fsc, output int urc,
                         output int sclk_bad, output int rdy_low);
    sdb = '0; lrb = '0; fsc = 0; urc = 0; sclk_bad = 0; rdy_low = 0;
    fs0 = four ? fs4 : fs;
    ur0 = four ? ur4 : ur;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      if ((four ? sclk4 : sclk) !== ((i % 4) >= 2)) sclk_bad++;
      if ((i % 4) == 0) begin
        sdb[i / 4] = four ? sd4 : sd;
        lrb[i / 4] = four ? lrclk4 : lrclk;
      end
      if (four ? fs4 : fs) fsc++;
      if (four ? ur4 : ur) urc++;
      if (!(four ? ready4 : ready)) rdy_low++;
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0; n_reset4 = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({sclk, lrclk, sd, ready, fs, ur} !== 6'b000100) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 000100", {sclk, lrclk, sd, ready, fs, ur});
    end
    tests++;
    if ({sclk4, lrclk4, sd4, ready4, fs4, ur4} !== 6'b000100) begin
      fails++;
      $display("FAIL reset_outputs4: got %b expected 000100", {sclk4, lrclk4, sd4, ready4, fs4, ur4});
    end
  endtask

  task automatic test_left_justified();
    logic [63:0] sdb, lrb; logic fs0, ur0; int fsc, urc, sb, rl; bit ok;
    logic [47:0] d;
    d = {24'h7FFFFE, 24'h800001};
    data = d; valid = 1'b1; mode = 1'b1;
    apply_reset(0);
    @(negedge clk);
    valid = 1'b0;
    tests++;
    if (ready !== 1'b0) begin fails++; $display("FAIL lj_ready_drop: got %b expected 0", ready); end
    wait_fs(0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL lj_first_load: no frame_start within bound"); end
    capture(0, sdb, lrb, fs0, ur0, fsc, urc, sb, rl);
    tests++;
    if (ur0 !== 1'b0) begin fails++; $display("FAIL lj_no_underrun: got %b expected 0", ur0); end
    tests++;
    if (sdb !== lj_expect(d)) begin fails++; $display("FAIL lj_sd: got %h expected %h", sdb, lj_expect(d)); end
    tests++;
    if (lrb !== LR_EXP) begin fails++; $display("FAIL lj_lrclk: got %h expected %h", lrb, LR_EXP); end
    tests++;
    if (sb != 0) begin fails++; $display("FAIL lj_sclk: got %0d bad samples expected 0", sb); end
    tests++;
    if (fsc != 1) begin fails++; $display("FAIL lj_fs_count: got %0d expected 1", fsc); end
    tests++;
    if (rl != 0) begin fails++; $display("FAIL lj_ready_after_load: got %0d low cycles expected 0", rl); end
    @(negedge clk);
    tests++;
    if ({fs, ur} !== 2'b11) begin fails++; $display("FAIL lj_second_load: got fs/ur %b expected 11", {fs, ur}); end
  endtask

  task automatic test_i2s();
    logic [63:0] sdb, lrb; logic fs0, ur0; int fsc, urc, sb, rl; bit ok;
    logic [47:0] d;
    d = {24'h7FFFFE, 24'h800001};
    data = d; valid = 1'b1; mode = 1'b0;
    apply_reset(0);
    @(negedge clk);
    valid = 1'b0;
    wait_fs(0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL i2s_first_load: no frame_start within bound"); end
    capture(0, sdb, lrb, fs0, ur0, fsc, urc, sb, rl);
    tests++;
    if (sdb !== i2s_expect(d, 1'b0)) begin
      fails++; $display("FAIL i2s_sd: got %h expected %h", sdb, i2s_expect(d, 1'b0));
    end
    tests++;
    if ({sdb[0], sdb[1], sdb[33]} !== 3'b010) begin
      fails++; $display("FAIL i2s_msb_pos: got b0/b1/b33 %b expected 010", {sdb[0], sdb[1], sdb[33]});
    end
    tests++;
    if (lrb !== LR_EXP) begin fails++; $display("FAIL i2s_lrclk: got %h expected %h", lrb, LR_EXP); end
  endtask

  task automatic test_underrun();
    logic [63:0] sdb, lrb; logic fs0, ur0; int fsc, urc, sb, rl; bit ok;
    int ur_total, rdy_total, bad_frames;
    valid = 1'b0; mode = 1'b1; data = 48'hFFFFFF_FFFFFF;
    apply_reset(0);
    wait_fs(0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL ur_first_load: no frame_start within bound"); end
    ur_total = 0; rdy_total = 0; bad_frames = 0;
    for (int f = 0; f < 3; f++) begin
      if (f > 0) @(negedge clk);
      capture(0, sdb, lrb, fs0, ur0, fsc, urc, sb, rl);
      ur_total += urc;
      rdy_total += rl;
      if (!(fs0 && ur0 && fsc == 1 && urc == 1 && sdb == '0 && lrb == LR_EXP)) bad_frames++;
    end
    tests++;
    if (ur_total != 3) begin fails++; $display("FAIL ur_count: got %0d expected 3", ur_total); end
    tests++;
    if (bad_frames != 0) begin fails++; $display("FAIL ur_frames: got %0d bad frames expected 0", bad_frames); end
    tests++;
    if (rdy_total != 0) begin fails++; $display("FAIL ur_ready: got %0d low cycles expected 0", rdy_total); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] sdb, lrb; logic fs0, ur0; int fsc, urc, sb, rl; bit ok;
    int k, rdy_fail;
    logic acc;
    valid = 1'b0; mode = 1'b1;
    apply_reset(0);
    wait_fs(0, ok);
    tests++;
    if (!ok || ur !== 1'b1) begin fails++; $display("FAIL b2b_first_underrun: got %b expected 1", ur); end
    k = 1; rdy_fail = 0;
    data = mk(1); valid = 1'b1; acc = ready;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          if (acc) begin
            if (ready !== 1'b0) rdy_fail++;
            k++;
            data = mk(k);
          end
          acc = valid && ready;
        end
      end
      begin
        repeat (256) @(negedge clk);
        for (int f = 1; f <= 3; f++) begin
          if (f > 1) @(negedge clk);
          capture(0, sdb, lrb, fs0, ur0, fsc, urc, sb, rl);
          tests++;
          if (!fs0 || urc != 0 || fsc != 1) begin
            fails++; $display("FAIL b2b_load%0d: got fs0=%b ur=%0d fs=%0d expected 1/0/1", f, fs0, urc, fsc);
          end
          tests++;
          if (sdb !== lj_expect(mk(f))) begin
            fails++; $display("FAIL b2b_frame%0d: got %h expected %h", f, sdb, lj_expect(mk(f)));
          end
        end
      end
    join
    valid = 1'b0;
    tests++;
    if (rdy_fail != 0) begin fails++; $display("FAIL b2b_ready_drop: got %0d misses expected 0", rdy_fail); end
    tests++;
    if (k != 5) begin fails++; $display("FAIL b2b_accepts: got %0d expected 4", k - 1); end
  endtask

  task automatic test_four_channels();
    logic [63:0] sdb, lrb; logic fs0, ur0; int fsc, urc, sb, rl; bit ok;
    logic [63:0] d;
    d = {16'hD, 16'hC, 16'hB, 16'hA};
    data4 = d; valid4 = 1'b1; mode4 = 1'b1;
    apply_reset(1);
    @(negedge clk);
    valid4 = 1'b0;
    wait_fs(1, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL ch4_first_load: no frame_start within bound"); end
    capture(1, sdb, lrb, fs0, ur0, fsc, urc, sb, rl);
    tests++;
    if (sdb !== ch4_expect(d)) begin fails++; $display("FAIL ch4_sd: got %h expected %h", sdb, ch4_expect(d)); end
    tests++;
    if (lrb !== LR_EXP) begin fails++; $display("FAIL ch4_lrclk: got %h expected %h", lrb, LR_EXP); end
    tests++;
    if (ur0 !== 1'b0 || sb != 0) begin fails++; $display("FAIL ch4_ur_sclk: got ur=%b sclk_bad=%0d expected 0/0", ur0, sb); end
  endtask

  task automatic test_async_reset();
    logic [63:0] sdb, lrb; logic fs0, ur0; int fsc, urc, sb, rl; bit ok;
    int early;
    data = {24'h000000, 24'hFFFFFF}; valid = 1'b1; mode = 1'b1;
    apply_reset(0);
    wait_fs(0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL ar_first_load: no frame_start within bound"); end
    repeat (42) @(negedge clk);
    tests++;
    if ({sclk, sd, ready} !== 3'b110) begin
      fails++; $display("FAIL ar_before: got sclk/sd/ready %b expected 110", {sclk, sd, ready});
    end
    #1 n_reset = 1'b0;
    #1;
    tests++;
    if ({sclk, lrclk, sd, ready, fs, ur} !== 6'b000100) begin
      fails++; $display("FAIL ar_async: got %b expected 000100", {sclk, lrclk, sd, ready, fs, ur});
    end
    valid = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    early = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (fs) early++;
    end
    @(negedge clk);
    tests++;
    if (early != 0 || fs !== 1'b1) begin
      fails++; $display("FAIL ar_reload_time: got early=%0d fs=%b expected 0/1", early, fs);
    end
    capture(0, sdb, lrb, fs0, ur0, fsc, urc, sb, rl);
    tests++;
    if (sdb !== '0 || ur0 !== 1'b1) begin
      fails++; $display("FAIL ar_residue: got sd=%h ur=%b expected 0/1", sdb, ur0);
    end
    tests++;
    if (lrb !== LR_EXP) begin fails++; $display("FAIL ar_lrclk: got %h expected %h", lrb, LR_EXP); end
  endtask

  initial begin
    n_reset = 1'b1; n_reset4 = 1'b1;
    valid = 1'b0; valid4 = 1'b0; mode = 1'b1; mode4 = 1'b1;
    data = '0; data4 = '0;
    #2;
    test_reset();
    test_left_justified();
    test_i2s();
    test_underrun();
    test_back_to_back();
    test_four_channels();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_tdm_transmitter.md
# i2s_tdm_transmitter

Parametrised serial audio transmitter and the successor of the fixed two-channel I2S transmitter. It divides the system clock to produce its own bit clock and serialises CHANNELS samples per frame. It supports I2S (one-bit delay) and left-justified framing, with configurable slot width and zero padding. It sits between the synthesiser mixer output and the DAC pins, and takes whole frames through a valid/ready handshake with a one-frame holding buffer and underrun reporting.

## Interface
- WORD_SIZE, 24, sample bits per channel; sent MSB first.
- SLOT_SIZE, 32, bits per channel slot; must be ≥ WORD_SIZE; bits beyond WORD_SIZE are sent as 0 after the LSB.
- CHANNELS, 2, channels per frame; even, ≥ 2.
- CLK_DIV, 4, clk cycles per sclk period; even, ≥ 2.

- clk  input  1  system clock; all logic on posedge.
- nReset  input  1  reset, asynchronous, active-low.
- sample_data  input  CHANNELS*WORD_SIZE  frame; channel k at [k*WORD_SIZE +: WORD_SIZE].
- sample_valid  input  1  sample_data holds a frame.
- sample_ready  output  1  holding buffer empty; the frame is accepted when valid && ready at posedge clk.
- mode  input  1  0 = I2S (one-bit delay), 1 = left-justified; latched only at frame load.
- sclk  output  1  bit clock, clk/CLK_DIV, 50% duty.
- lrclk  output  1  low for channels 0..CHANNELS/2-1, high for the rest.
- sd  output  1  serial data; changes on the sclk falling edge.
- frame_start  output  1  one-clk pulse on the cycle a frame loads.
- underrun  output  1  one-clk pulse when a frame loads with the holding buffer empty.

## Operation
- FRAME = CHANNELS*SLOT_SIZE bits. Bit counter b runs 0..FRAME-1 and advances on each sclk falling edge, wrapping to 0.
- Divider: div_cnt runs 0..CLK_DIV-1.
  - div_cnt reaching CLK_DIV/2 sets sclk=1.
  - div_cnt wrapping to 0 sets sclk=0; this is the "fall tick".
- Frame load happens on the fall tick where b becomes 0:
  - If the holding buffer is full, the shift register takes the holding buffer, padded per slot, and the holding buffer becomes empty.
  - If the holding buffer is empty, the shift register loads all zeros and underrun pulses.
  - In both cases mode is latched and frame_start pulses.
- Holding buffer:
  - Accepts one frame when sample_valid && sample_ready.
  - sample_ready = holding buffer empty, registered.
  - An accept in the same clk as a load with an empty buffer is not bypassed: the load underruns and the new frame waits for the next load.
- Left-justified: lrclk = (b ≥ FRAME/2). sd = slot bit (SLOT_SIZE-1 - b mod SLOT_SIZE) of the current frame.
- I2S: lrclk is as in left-justified. sd is delayed one bit: at b, sd carries frame bit b-1; at b=0 it carries the final bit of the previous frame (0 after reset).
- No other states: the transmitter runs continuously from reset release. Zero frames are sent during underrun and lrclk keeps running.

## Timing
- Reset values: sclk=0, lrclk=0, sd=0, sample_ready=1, frame_start=0, underrun=0.
  - Internal state after reset: div_cnt=0, b=FRAME-1, holding buffer empty, shift register and delay flop cleared, latched mode=0.
- Reset asserted mid-frame clears everything immediately, asynchronously. After release, the first fall tick is CLK_DIV clks later and loads frame 0.
- sclk, lrclk, sd, frame_start and underrun are all registered. lrclk and sd update in the same clk as sclk falls, so each bit is stable across the following sclk rising edge.
- Accept-to-ready: sample_ready drops in the clk after an accept and rises in the clk after the next load.
- Minimum input throughput is one frame per FRAME*CLK_DIV clks. Each accepted frame is sent exactly once, in order.

## Test plan
- Defaults, mode=1, sample_data={24'h7FFFFE, 24'h800001} accepted before the first load → sclk period 4 clks. lrclk is low for 32 sclk, then high for 32. sd slot 0 = 1, twenty-two 0s, 1, eight 0s; slot 1 = 0, twenty-two 1s, 0, eight 0s. frame_start pulses once per 256 clks.
- Same data, mode=0 → the ch0 MSB appears on the first sclk after lrclk falls. The bit at b=0 of the first frame is 0. The ch1 MSB appears at b=33.
- No sample_valid for 3 frames → sd constant 0, lrclk toggling, underrun pulses 3 times coincident with frame_start, sample_ready stays 1.
- sample_valid held high with incrementing data 1,2,3... → ready drops after each accept. Frames 1,2,3 are transmitted in order with none skipped or repeated, and underrun pulses only on the first load after reset.
- CHANNELS=4, WORD_SIZE=SLOT_SIZE=16, mode=1, channels {16'hD, 16'hC, 16'hB, 16'hA} → 64-bit frame. lrclk is low for channels A and B and high for C and D. No padding bits.
- nReset pulled low at b=10 → all outputs go to reset values without waiting for a clk edge. After release, a new frame loads after 4 clks starting at b=0, with no residue from the interrupted frame.
